// File: rtl/wdt_pkg.sv
// Shared types and constants for the multi-channel watchdog.
// Pure definitions; no logic, no latency, no backpressure.
package wdt_pkg;

  typedef enum logic [1:0] {
    WDT_IDLE = 2'd0,
    WDT_RUN  = 2'd1,
    WDT_TRIP = 2'd2
  } wdt_state_e;

  localparam int WDT_TIMEOUT_DEFAULT = 127;

  // Width of a channel index bus; a single channel still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wdt_chan.sv
// One watchdog channel: countdown, IDLE/RUN/TRIP state, sticky fault.
// trip/fault registered (1 cycle after the terminal tick); no backpressure, events level-sampled.
module wdt_chan
  import wdt_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit STICKY = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             kick,
  input  logic             disarm,
  input  logic             clr,
  input  logic [WIDTH-1:0] tmo_eff,
  output logic             trip,
  output logic             fault
);

  wdt_state_e       state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             fault_set;

  // Priority: disarm > kick > tick. Encoding 2'd3 falls into default and recovers to IDLE.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fault_set = 1'b0;
    if (disarm) begin
      state_d = WDT_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        WDT_IDLE: begin
          if (kick) begin
            state_d = WDT_RUN;
            cnt_d   = tmo_eff;
          end
        end
        WDT_RUN: begin
          if (kick) begin
            cnt_d = tmo_eff;
          end else if (tick) begin
            if (cnt_q == '0) begin
              state_d   = WDT_TRIP;
              fault_set = 1'b1;
            end else begin
              cnt_d = cnt_q - WIDTH'(1);
            end
          end
        end
        WDT_TRIP: begin
          if (kick && !STICKY) begin
            state_d = WDT_RUN;
            cnt_d   = tmo_eff;
          end
        end
        default: begin
          state_d = WDT_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WDT_IDLE;
      cnt_q   <= '0;
      trip    <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trip    <= (state_d == WDT_TRIP);
      // A new trip outranks a clear arriving in the same cycle.
      fault   <= fault_set | (fault & ~clr);
    end
  end

endmodule

// File: rtl/wdt_multi.sv
// Multi-channel watchdog: per-channel timeout registers with write bypass into kick reloads.
// trip/fault 1 cycle after terminal tick, any_trip combinational from trip; no backpressure.
module wdt_multi
  import wdt_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 16,
  parameter int TIMEOUT_RST = WDT_TIMEOUT_DEFAULT,
  parameter bit STICKY      = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tick,
  input  logic [CHANNELS-1:0]           kick,
  input  logic [CHANNELS-1:0]           disarm,
  input  logic                          ld,
  input  logic [idx_w(CHANNELS)-1:0]    ld_chan,
  input  logic [WIDTH-1:0]              ld_val,
  input  logic [CHANNELS-1:0]           clr_fault,
  output logic [CHANNELS-1:0]           trip,
  output logic                          any_trip,
  output logic [CHANNELS-1:0]           fault
);

  localparam int LDW = idx_w(CHANNELS);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic             ld_hit;
    logic [WIDTH-1:0] tmo_q;
    logic [WIDTH-1:0] tmo_eff;

    // Indices past the last channel match no slot and are dropped.
    assign ld_hit  = ld && (ld_chan == LDW'(c));
    assign tmo_eff = ld_hit ? ld_val : tmo_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        tmo_q <= WIDTH'(TIMEOUT_RST);
      end else if (ld_hit) begin
        tmo_q <= ld_val;
      end
    end

    wdt_chan #(
      .WIDTH  (WIDTH),
      .STICKY (STICKY)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .kick    (kick[c]),
      .disarm  (disarm[c]),
      .clr     (clr_fault[c]),
      .tmo_eff (tmo_eff),
      .trip    (trip[c]),
      .fault   (fault[c])
    );
  end

  assign any_trip = |trip;

endmodule

// File: tb/tb_wdt_multi.sv
// Bench for wdt_multi: a sticky 4x16-bit instance and a non-sticky 3x6-bit instance
// against a ticks-remaining reference model, with directed phases then random traffic.
module tb_wdt_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick = 1'b0;

  logic [3:0]  kick_a = '0, disarm_a = '0, clr_a = '0;
  logic        ld_a = 1'b0;
  logic [1:0]  ld_chan_a = '0;
  logic [15:0] ld_val_a = '0;
  logic [3:0]  trip_a, fault_a;
  logic        any_a;

  logic [2:0]  kick_b = '0, disarm_b = '0, clr_b = '0;
  logic        ld_b = 1'b0;
  logic [1:0]  ld_chan_b = '0;
  logic [5:0]  ld_val_b = '0;
  logic [2:0]  trip_b, fault_b;
  logic        any_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wdt_multi #(.CHANNELS(4), .WIDTH(16), .TIMEOUT_RST(127), .STICKY(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .tick(tick), .kick(kick_a), .disarm(disarm_a),
    .ld(ld_a), .ld_chan(ld_chan_a), .ld_val(ld_val_a), .clr_fault(clr_a),
    .trip(trip_a), .any_trip(any_a), .fault(fault_a)
  );

  wdt_multi #(.CHANNELS(3), .WIDTH(6), .TIMEOUT_RST(10), .STICKY(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .tick(tick), .kick(kick_b), .disarm(disarm_b),
    .ld(ld_b), .ld_chan(ld_chan_b), .ld_val(ld_val_b), .clr_fault(clr_b),
    .trip(trip_b), .any_trip(any_b), .fault(fault_b)
  );

  // Reference model: mode 0 idle, 1 running, 2 tripped; left = ticks still needed to trip.
  int m_tmo  [2][4];
  int m_left [2][4];
  int m_mode [2][4];
  bit m_flt  [2][4];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_dut(input int d, input int nch, input int rstval, input bit sticky,
                           input logic [3:0] k, input logic [3:0] dis, input logic [3:0] clr,
                           input logic ld, input int ldc, input int ldv);
    for (int c = 0; c < nch; c++) begin
      if (rst) begin
        m_mode[d][c] = 0;
        m_left[d][c] = 0;
        m_flt[d][c]  = 1'b0;
        m_tmo[d][c]  = rstval;
      end else begin
        bit hit, set;
        int eff;
        hit = ld && (ldc == c);
        eff = hit ? ldv : m_tmo[d][c];
        set = 1'b0;
        if (dis[c]) begin
          m_mode[d][c] = 0;
        end else if (k[c] && (m_mode[d][c] != 2 || !sticky)) begin
          m_mode[d][c] = 1;
          m_left[d][c] = eff + 1;
        end else if (tick && m_mode[d][c] == 1) begin
          m_left[d][c]--;
          if (m_left[d][c] == 0) begin
            m_mode[d][c] = 2;
            set = 1'b1;
          end
        end
        if (set)         m_flt[d][c] = 1'b1;
        else if (clr[c]) m_flt[d][c] = 1'b0;
        if (hit) m_tmo[d][c] = ldv;
      end
    end
  endtask

  function automatic logic [31:0] exp_trip(input int d, input int nch);
    logic [31:0] v = '0;
    for (int c = 0; c < nch; c++) v[c] = (m_mode[d][c] == 2);
    return v;
  endfunction

  function automatic logic [31:0] exp_fault(input int d, input int nch);
    logic [31:0] v = '0;
    for (int c = 0; c < nch; c++) v[c] = m_flt[d][c];
    return v;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_dut(0, 4, 127, 1'b1, kick_a, disarm_a, clr_a, ld_a, int'(ld_chan_a), int'(ld_val_a));
    model_dut(1, 3, 10, 1'b0, {1'b0, kick_b}, {1'b0, disarm_b}, {1'b0, clr_b},
              ld_b, int'(ld_chan_b), int'(ld_val_b));
    #1;
    check_eq("a_trip",  32'(trip_a),  exp_trip(0, 4));
    check_eq("a_fault", 32'(fault_a), exp_fault(0, 4));
    check_eq("a_any",   32'(any_a),   32'(|exp_trip(0, 4)));
    check_eq("b_trip",  32'(trip_b),  exp_trip(1, 3));
    check_eq("b_fault", 32'(fault_b), exp_fault(1, 3));
    check_eq("b_any",   32'(any_b),   32'(|exp_trip(1, 3)));
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask

  initial begin
    rst = 1'b1;
    cyc();
    cyc();
    check_eq("rst_trip_a", 32'(trip_a), 32'd0);
    check_eq("rst_fault_a", 32'(fault_a), 32'd0);
    check_eq("rst_any_b", 32'(any_b), 32'd0);
    rst = 1'b0;
    cyc();

    // Default timeout of 127: trips on the 128th tick, clear in the same cycle loses.
    kick_a[0] = 1'b1; cyc(); kick_a = '0;
    tick_n(127);
    check_eq("dflt_127_no_trip", 32'(trip_a[0]), 32'd0);
    tick = 1'b1; clr_a[0] = 1'b1; cyc(); tick = 1'b0; clr_a = '0;
    check_eq("dflt_128_trip", 32'(trip_a[0]), 32'd1);
    check_eq("dflt_fault_vs_clr", 32'(fault_a[0]), 32'd1);
    check_eq("dflt_any_trip", 32'(any_a), 32'd1);
    kick_a[0] = 1'b1; cyc(); kick_a = '0;
    check_eq("sticky_kick_ignored", 32'(trip_a[0]), 32'd1);
    disarm_a[0] = 1'b1; cyc(); disarm_a = '0;
    check_eq("disarm_trip", 32'(trip_a[0]), 32'd0);
    check_eq("disarm_keeps_fault", 32'(fault_a[0]), 32'd1);
    clr_a[0] = 1'b1; cyc(); clr_a = '0;
    cyc();
    check_eq("clr_fault", 32'(fault_a[0]), 32'd0);

    // Periodic kicking of ch1 with timeout 3.
    ld_a = 1'b1; ld_chan_a = 2'd1; ld_val_a = 16'd3; cyc(); ld_a = 1'b0;
    for (int t = 0; t < 50; t++) begin
      kick_a[1] = (t % 3 == 0);
      tick = 1'b1; cyc(); tick = 1'b0; kick_a = '0; cyc();
      check_eq("periodic_no_trip", 32'(trip_a[1]), 32'd0);
    end
    kick_a[1] = 1'b1; cyc(); kick_a = '0;
    tick_n(3);
    check_eq("stop_kick_3", 32'(trip_a[1]), 32'd0);
    tick_n(1);
    check_eq("stop_kick_4", 32'(trip_a[1]), 32'd1);

    // Kick coinciding with a terminal tick reloads instead of tripping.
    ld_a = 1'b1; ld_chan_a = 2'd3; ld_val_a = 16'd2; cyc(); ld_a = 1'b0;
    kick_a[3] = 1'b1; cyc(); kick_a = '0;
    tick_n(2);
    kick_a[3] = 1'b1; tick = 1'b1; cyc(); kick_a = '0; tick = 1'b0;
    check_eq("kick_tick_at_zero", 32'(trip_a[3]), 32'd0);
    tick_n(2);
    check_eq("reload_hold", 32'(trip_a[3]), 32'd0);
    tick_n(1);
    check_eq("reload_trip", 32'(trip_a[3]), 32'd1);

    // Write bypass: ld and kick together use the new value.
    ld_a = 1'b1; ld_chan_a = 2'd2; ld_val_a = 16'd5; kick_a[2] = 1'b1; cyc();
    ld_a = 1'b0; kick_a = '0;
    tick_n(5);
    check_eq("bypass_5", 32'(trip_a[2]), 32'd0);
    tick_n(1);
    check_eq("bypass_6", 32'(trip_a[2]), 32'd1);

    ld_a = 1'b1; ld_chan_a = 2'd0; ld_val_a = 16'd0; cyc(); ld_a = 1'b0;
    kick_a[0] = 1'b1; cyc(); kick_a = '0;
    tick_n(1);
    check_eq("tmo_zero", 32'(trip_a[0]), 32'd1);

    // Out-of-range ld index on the 3-channel instance, then full 6-bit range.
    ld_b = 1'b1; ld_chan_b = 2'd3; ld_val_b = 6'd1; cyc();
    ld_chan_b = 2'd0; ld_val_b = 6'd63; cyc(); ld_b = 1'b0;
    kick_b = 3'b111; cyc(); kick_b = '0;
    tick_n(10);
    check_eq("b_ld_ignored_hold", 32'(trip_b), 32'd0);
    tick_n(1);
    check_eq("b_ld_ignored_trip", 32'(trip_b), 32'b110);
    tick_n(52);
    check_eq("b_full_range_hold", 32'(trip_b[0]), 32'd0);
    tick_n(1);
    check_eq("b_full_range_trip", 32'(trip_b[0]), 32'd1);
    kick_b[0] = 1'b1; cyc(); kick_b = '0;
    check_eq("b_nonsticky_kick", 32'(trip_b[0]), 32'd0);

    // Reset mid-count restores the default timeouts.
    kick_a = 4'hf; cyc(); kick_a = '0;
    tick_n(1);
    rst = 1'b1; cyc(); rst = 1'b0;
    check_eq("mid_rst_trip_a", 32'(trip_a), 32'd0);
    check_eq("mid_rst_trip_b", 32'(trip_b), 32'd0);
    kick_a[1] = 1'b1; cyc(); kick_a = '0;
    tick_n(4);
    check_eq("mid_rst_tmo_restored", 32'(trip_a[1]), 32'd0);

    for (int i = 0; i < 2500; i++) begin
      tick      = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 499) == 0);
      for (int c = 0; c < 4; c++) begin
        kick_a[c]   = ($urandom_range(0, 15) == 0);
        disarm_a[c] = ($urandom_range(0, 63) == 0);
        clr_a[c]    = ($urandom_range(0, 15) == 0);
      end
      for (int c = 0; c < 3; c++) begin
        kick_b[c]   = ($urandom_range(0, 15) == 0);
        disarm_b[c] = ($urandom_range(0, 63) == 0);
        clr_b[c]    = ($urandom_range(0, 15) == 0);
      end
      ld_a      = ($urandom_range(0, 31) == 0);
      ld_chan_a = 2'($urandom_range(0, 3));
      ld_val_a  = 16'($urandom_range(0, 7));
      ld_b      = ($urandom_range(0, 31) == 0);
      ld_chan_b = 2'($urandom_range(0, 3));
      ld_val_b  = 6'($urandom_range(0, 7));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
